// File: rtl/computing_core_ctrl.sv
// Tile sequencer for the 64-lane sparse 4-bit computing_core: fetch, issue, wait, present.
// Optional busy/stall performance counters are built when CORE_CTRL_PERF_EN is defined.
module computing_core_ctrl #(
  parameter int CORE_LATENCY = 3,
  parameter int TILE_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TILE_CNT_W-1:0] num_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  w_rd_en,
  output logic [TILE_CNT_W-1:0] w_rd_addr,
  output logic                  a_rd_en,
  output logic [TILE_CNT_W-1:0] a_rd_addr,
  output logic                  core_load,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [TILE_CNT_W-1:0] res_tile_idx,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stall
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                state;
  logic [TILE_CNT_W-1:0] tile_q;
  logic [TILE_CNT_W-1:0] n_q;
  logic [3:0]            wait_cnt;
  logic                  last_tile;
  logic                  start_acc;

  assign last_tile = (tile_q == n_q - TILE_CNT_W'(1));
  assign start_acc = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tile_q   <= '0;
      n_q      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_q    <= num_tiles;
            tile_q <= '0;
            state  <= (num_tiles == '0) ? DONE : FETCH;
          end
        end
        FETCH: state <= ISSUE;
        ISSUE: begin
          wait_cnt <= 4'(CORE_LATENCY - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= OUT;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        OUT: begin
          if (res_ready) begin
            if (last_tile) begin
              state <= DONE;
            end else begin
              tile_q <= tile_q + TILE_CNT_W'(1);
              state  <= FETCH;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight off the state register so reset clears them without a clock.
  assign busy         = (state == FETCH) || (state == ISSUE) || (state == WAIT) || (state == OUT);
  assign done         = (state == DONE);
  assign w_rd_en      = (state == FETCH);
  assign a_rd_en      = (state == FETCH);
  assign core_load    = (state == ISSUE);
  assign res_valid    = (state == OUT);
  assign w_rd_addr    = tile_q;
  assign a_rd_addr    = tile_q;
  assign res_tile_idx = tile_q;

`ifdef CORE_CTRL_PERF_EN
  logic [31:0] cyc_q;
  logic [31:0] stall_q;

  // Saturating counters; values survive DONE/IDLE until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else if (start_acc) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (busy && (cyc_q != 32'hFFFF_FFFF))
        cyc_q <= cyc_q + 32'd1;
      if ((state == OUT) && !res_ready && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_stall  = stall_q;
`else
  logic unused_perf;
  assign unused_perf = start_acc;
  assign perf_cycles = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: doc/computing_core_ctrl.md
# computing_core_ctrl

Tile sequencer for the 64-lane sparse 4-bit `computing_core`. On `start` it walks `num_tiles` tiles. For each tile it:
- reads one weight word and one activation word from the on-chip buffers,
- strobes the core input registers,
- waits out the core pipeline,
- presents the tile result to the downstream writer through a valid/ready handshake.

It sits between the buffer subsystem, `computing_core`, and the result writeback path.

## Interface
- `CORE_LATENCY`, default 3: cycles from `core_load` to a valid `o_result` at the core output. Legal range 1..15.
- `TILE_CNT_W`, default 8: width of tile count, index and buffer addresses.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run. Sampled only in IDLE.
- `num_tiles`  in  TILE_CNT_W  tiles in the run. Latched when `start` is accepted.
- `busy`  out  1  high in FETCH, ISSUE, WAIT and OUT.
- `done`  out  1  one-cycle pulse at the end of a run.
- `w_rd_en`  out  1  weight buffer read strobe. Data arrives 1 cycle later.
- `w_rd_addr`  out  TILE_CNT_W  weight buffer address, equal to the current tile index.
- `a_rd_en`  out  1  activation buffer read strobe. Data arrives 1 cycle later.
- `a_rd_addr`  out  TILE_CNT_W  activation buffer address, equal to the current tile index.
- `core_load`  out  1  capture enable for the core's `i_Weight`/`i_Activation` registers.
- `res_valid`  out  1  the core `o_result` holds the current tile's result.
- `res_ready`  in  1  the downstream writer accepts the result.
- `res_tile_idx`  out  TILE_CNT_W  index of the tile being presented.
- `perf_cycles`  out  32  busy-cycle count for the last run. Zero when the perf macro is not defined.
- `perf_stall`  out  32  OUT cycles with `res_ready`=0. Zero when the perf macro is not defined.

## Operation
- FSM states: IDLE, FETCH, ISSUE, WAIT, OUT, DONE. State is registered.
- **IDLE:** on `start`=1:
  - latch `num_tiles` into `n_q` and set `tile_q`=0;
  - if `num_tiles`=0, go to DONE; otherwise go to FETCH.
- **FETCH (1 cycle):** drive `w_rd_en`=`a_rd_en`=1 with both addresses = `tile_q`, then go to ISSUE.
- **ISSUE (1 cycle):** drive `core_load`=1 while the buffer data is valid. Load `wait_cnt`=CORE_LATENCY-1, then go to WAIT.
- **WAIT:** decrement `wait_cnt` each cycle; when it reaches 0, go to OUT. WAIT lasts exactly CORE_LATENCY cycles.
- **OUT:** drive `res_valid`=1 and `res_tile_idx`=`tile_q`. Stay in OUT while `res_ready`=0. On `res_ready`=1:
  - if `tile_q`=`n_q`-1, go to DONE;
  - otherwise increment `tile_q` and go to FETCH.
- **DONE (1 cycle):** drive `done`=1, then go to IDLE.
- `start` outside IDLE is ignored; there is no queuing or restart.
- `num_tiles` changes after acceptance have no effect.
- Strobes (`w_rd_en`, `a_rd_en`, `core_load`, `res_valid`, `done`) are decoded from state and are high only in the states listed above.
- Each tile costs CORE_LATENCY+3 cycles when `res_ready` is held high.

## Timing
- Reset values: state=IDLE, `tile_q`=0, `n_q`=0, `wait_cnt`=0; all outputs 0, including the perf counters.
- Reset mid-run aborts immediately:
  - no `done` pulse;
  - `res_valid` drops asynchronously;
  - buffer and core contents are not touched.
- With `start` accepted at edge E0 and `res_ready`=1, tile k has:
  - FETCH in cycle 1+(L+3)k;
  - ISSUE in cycle 2+(L+3)k;
  - WAIT in cycles 3..L+2 offset by (L+3)k;
  - OUT in cycle L+3+(L+3)k.
- `done` is high in cycle 1+(L+3)N.
- `busy` stays high throughout a run, including OUT stall cycles. It is low in IDLE and DONE.
- Handshake rules:
  - `res_valid` never drops without `res_ready`;
  - `res_tile_idx` is stable while `res_valid`=1;
  - the transfer happens on the edge where both are 1.
- A `start` arriving in the same cycle as DONE is ignored. It is accepted at the earliest in the following IDLE cycle.

## Configuration
- `CORE_CTRL_PERF_EN` defined:
  - `perf_cycles` and `perf_stall` are cleared when `start` is accepted;
  - `perf_cycles` increments every cycle `busy`=1;
  - `perf_stall` increments every OUT cycle with `res_ready`=0;
  - both saturate at 32'hFFFF_FFFF and hold their values after DONE until the next accepted `start`.
- `CORE_CTRL_PERF_EN` undefined: the counters are not instantiated and both ports are tied to 0.

## Test plan
- CORE_LATENCY=3, `num_tiles`=4, `res_ready`=1, `start` at E0:
  - read addresses 0,1,2,3 in cycles 1, 7, 13, 19;
  - `core_load` in cycles 2, 8, 14, 20;
  - `res_valid` in cycles 6, 12, 18, 24;
  - `done` in cycle 25;
  - `perf_cycles`=24, `perf_stall`=0.
- `num_tiles`=0, `start`=1 -> `done` in cycle 1; no `w_rd_en`, `a_rd_en`, `core_load` or `res_valid` ever asserted; `busy` stays 0.
- `num_tiles`=2 with `res_ready` held low for 5 cycles on tile 0:
  - `res_valid` and `res_tile_idx`=0 are held stable for 6 cycles;
  - `done` arrives 5 cycles later than nominal, in cycle 18;
  - `perf_stall`=5.
- Pulse `start` again mid-run at tile 1 with `num_tiles` changed to 9 -> ignored; the run completes with the original count and only one `done`.
- Assert `rst` during WAIT of tile 2 -> all outputs 0 immediately, no `done`. After release, a `start` with `num_tiles`=1 runs normally starting at address 0.
- CORE_LATENCY=1, `num_tiles`=255 -> 4-cycle tiles, last `res_tile_idx`=254, `done` in cycle 1021, no wrap of `tile_q`.
